// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared opcode/func constants, ALUOp encoding, FSM state enum and ID dispatch
// Used by mc_control_unit and alu_op_decode. Configuration macro: MC_CTRL_ILLEGAL_HALT_EN
// (defined: undefined opcodes/funcs halt; undefined: they retire as NOPs).
package mc_ctrl_pkg;
   localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_BGZ = 4'd2, OP_BLZ = 4'd3,
                          OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7,
                          OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_RTYPE = 4'd15;
   localparam logic [5:0] FN_ADD = 6'd0, FN_SHR = 6'd7, FN_JPR = 6'd25, FN_JRL = 6'd26,
                          FN_WWD = 6'd28, FN_HLT = 6'd29;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_ORR = 4'd3,
                          ALU_NOT = 4'd4, ALU_TCP = 4'd5, ALU_SHL = 4'd6, ALU_SHR = 4'd7,
                          ALU_LHI = 4'd8, ALU_ORI = 4'd9, ALU_BNE = 4'd10, ALU_BEQ = 4'd11,
                          ALU_BGZ = 4'd12, ALU_BLZ = 4'd13;
   typedef enum logic [4:0] {
      S_BOOT, S_IF, S_IF_INC, S_ID, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_EX_MEM, S_MEM_RD,
      S_WB_LD, S_MEM_WR, S_EX_BR, S_JMP, S_JAL, S_JPR, S_JRL, S_WWD, S_HLT
   } state_t;
   typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BR} alu_cls_t;
   function automatic state_t id_next(input logic [3:0] op, input logic [5:0] fn);
      state_t ill;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      ill = S_HLT;
`else
      ill = S_IF;
`endif
      return op <= OP_BLZ   ? S_EX_BR  :
             op <= OP_LHI   ? S_EX_I   :
             op <= OP_SWD   ? S_EX_MEM :
             op == OP_JMP   ? S_JMP    :
             op == OP_JAL   ? S_JAL    :
             op != OP_RTYPE ? ill      :
             fn <= FN_SHR   ? S_EX_R   :
             fn == FN_JPR   ? S_JPR    :
             fn == FN_JRL   ? S_JRL    :
             fn == FN_WWD   ? S_WWD    :
             fn == FN_HLT   ? S_HLT    : ill;
   endfunction
endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: control unit <-> datapath bundle
// master (control unit): inputs opcode/func_code/inputReady, outputs every strobe/select/status.
// slave (datapath): the mirror image.
interface mc_control_unit_if;
   logic [3:0] opcode;
   logic [5:0] func_code;
   logic       inputReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0] PCSource, MemtoReg, RegDst, ALUSrcB;
   logic [3:0] ALUOp;
   logic       isWWD, isHalted, done;
   modport master (
      input  opcode, func_code, inputReady,
      output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, isWWD, isHalted, done
   );
   modport slave (
      output opcode, func_code, inputReady,
      input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, isWWD, isHalted, done
   );
endinterface

// File: rtl/mc_control_unit_alu_op_decode.sv
// alu_op_decode: combinational ALUOp select from opcode, func_code and the state's ALU class
// Ports: opcode, func_code (IR fields), cls (ALU class of current state) -> alu_op.
module alu_op_decode
   import mc_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [5:0] func_code,
   input  alu_cls_t   cls,
   output logic [3:0] alu_op
);
   always_comb
      alu_op = cls == CLS_R  ? (func_code <= FN_SHR ? func_code[3:0] : ALU_ADD) :
               cls == CLS_I  ? (opcode == OP_ORI ? ALU_ORI : opcode == OP_LHI ? ALU_LHI : ALU_ADD) :
               cls == CLS_BR ? ALU_BNE + {2'b00, opcode[1:0]} :
               ALU_ADD;
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle Moore control FSM (fetch/decode/execute/memory/write-back)
// Ports: clk, reset_n (async active-low), bus (mc_control_unit_if.master).
// Parameter STATE_W: state register width (>= 5). Macro MC_CTRL_ILLEGAL_HALT_EN selects
// halt-on-illegal instead of NOP-on-illegal.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W = 5
)(
   input logic               clk,
   input logic               reset_n,
   mc_control_unit_if.master bus
);
   logic [STATE_W-1:0] state_q;
   state_t             state, nxt;
   alu_cls_t           cls;
   logic               done_q, link;
   assign state    = state_t'(state_q[4:0]);
   assign bus.done = done_q;
   assign link     = state == S_JAL || state == S_JRL;
   assign cls      = (state == S_EX_R || state == S_WB_R) ? CLS_R :
                     state == S_EX_I  ? CLS_I  :
                     state == S_EX_BR ? CLS_BR : CLS_ADD;
   alu_op_decode u_alu_op_decode (
      .opcode    (bus.opcode),
      .func_code (bus.func_code),
      .cls       (cls),
      .alu_op    (bus.ALUOp)
   );
   // done flags the cycle after an instruction's last state: entry into IF (not from BOOT) or HLT.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= STATE_W'(S_BOOT);
         done_q  <= 1'b0;
      end else begin
         state_q <= STATE_W'(nxt);
         done_q  <= (nxt == S_IF && state != S_IF && state != S_BOOT) || (nxt == S_HLT && state != S_HLT);
      end
   always_comb begin
      nxt             = S_IF;
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.PCSource    = 2'b00;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 2'b00;
      bus.RegDst      = 2'b00;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.isWWD       = 1'b0;
      bus.isHalted    = 1'b0;
      case (state)
         S_IF:     begin nxt = bus.inputReady ? S_IF_INC : S_IF; bus.MemRead = 1'b1; bus.IRWrite = 1'b1; end
         S_IF_INC: begin nxt = S_ID; bus.ALUSrcB = 2'b01; bus.PCWrite = 1'b1; end
         S_ID:     begin nxt = id_next(bus.opcode, bus.func_code); bus.ALUSrcB = 2'b10; end
         S_EX_R:   begin nxt = S_WB_R; bus.ALUSrcA = 1'b1; end
         S_WB_R:   begin bus.ALUSrcA = 1'b1; bus.RegWrite = 1'b1; bus.RegDst = 2'b01; end
         S_EX_I:   begin nxt = S_WB_I; bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
         S_WB_I:   bus.RegWrite = 1'b1;
         S_EX_MEM: begin nxt = bus.opcode == OP_LWD ? S_MEM_RD : S_MEM_WR; bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
         S_MEM_RD: begin nxt = bus.inputReady ? S_WB_LD : S_MEM_RD; bus.IorD = 1'b1; bus.MemRead = 1'b1; end
         S_WB_LD:  begin bus.RegWrite = 1'b1; bus.MemtoReg = 2'b01; end
         S_MEM_WR: begin nxt = bus.inputReady ? S_IF : S_MEM_WR; bus.IorD = 1'b1; bus.MemWrite = 1'b1; end
         S_EX_BR:  begin bus.ALUSrcA = 1'b1; bus.PCWriteCond = 1'b1; bus.PCSource = 2'b01; end
         S_JMP, S_JAL, S_JPR, S_JRL: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = (state == S_JMP || state == S_JAL) ? 2'b10 : 2'b11;
            bus.RegWrite = link;
            bus.RegDst   = link ? 2'b10 : 2'b00;
            bus.MemtoReg = link ? 2'b10 : 2'b00;
         end
         S_WWD:    bus.isWWD = 1'b1;
         S_HLT:    begin nxt = S_HLT; bus.isHalted = 1'b1; end
         default:  nxt = S_IF;
      endcase
   end
endmodule
